cache_port_rr_arbiter: RTL
==========================

// Module: cache_port_rr_arbiter
// PURPOSE
//   Parametrised N-master to 1-slave OBI-style arbiter placed in front of the data cache core port.
//   Round-robin grants with request lock-in while the slave stalls.
//   An order FIFO tracks up to MAX_OUTSTANDING in-flight requests, so each rvalid/rdata/err goes back to the master that issued it.
//   Master ports are flat vectors; interface adaptation is done in the SoC wrapper.
// PARAMETERS
//   NR_MASTERS       4   number of master ports, >=2
//   ADDR_WIDTH       32  address width
//   DATA_WIDTH       32  data width; BE width = DATA_WIDTH/8
//   MAX_OUTSTANDING  2   order FIFO depth, >=1; any value allowed (no power-of-2 requirement)
//   CNT_WIDTH        32  width of each perf counter (CACHE_ARB_PERF_EN only)
// PORTS
//   clk_i          in   1                   clock
//   rst_i          in   1                   synchronous reset, active-high
//   mst_req_i      in   NR_MASTERS          per-master request
//   mst_gnt_o      out  NR_MASTERS          per-master grant
//   mst_we_i       in   NR_MASTERS          per-master write enable
//   mst_be_i       in   NR_MASTERS*BE_W     per-master byte enables
//   mst_addr_i     in   NR_MASTERS*ADDR_W   per-master address
//   mst_wdata_i    in   NR_MASTERS*DATA_W   per-master write data
//   mst_rvalid_o   out  NR_MASTERS          per-master response valid
//   mst_rdata_o    out  DATA_WIDTH          read data, broadcast to all masters
//   mst_err_o      out  DATA_WIDTH?no:1     response error, broadcast to all masters
//   slv_req_o      out  1                   request to cache
//   slv_gnt_i      in   1                   grant from cache
//   slv_we_o / slv_be_o / slv_addr_o / slv_wdata_o   out   selected master's fields
//   slv_rvalid_i   in   1                   response valid from cache
//   slv_rdata_i    in   DATA_WIDTH          read data from cache
//   slv_err_i      in   1                   error from cache
//   outstanding_o  out  clog2(MAX_OUTSTANDING+1)   current FIFO fill level
//   spurious_o     out  1                   1-cycle pulse: rvalid arrived while FIFO empty
//   perf_gnt_cnt_o out  NR_MASTERS*CNT_WIDTH  per-master grant counters (CACHE_ARB_PERF_EN only)
// BEHAVIOUR
//   Reset (synchronous, rst_i=1 at clk_i edge):
//     - rr pointer=0, lock cleared, FIFO empty, counters=0.
//     - All registered outputs are 0: outstanding_o=0, spurious_o=0.
//   Request path (combinational, zero-cycle latency):
//     - slv_req_o = |mst_req_i & !full.
//     - Slave fields are muxed from the selected index sel.
//   Selection:
//     - Unlocked: sel = first requesting master at or after rr pointer, modulo NR_MASTERS.
//     - Locked: sel = latched index.
//   Lock-in:
//     - Set when slv_req_o=1 and slv_gnt_i=0; latches sel.
//     - Cleared on handshake (slv_req_o & slv_gnt_i).
//     - Masters must hold req and fields stable until granted; no withdrawal is supported.
//   Grant:
//     - mst_gnt_o[sel] = slv_gnt_i & slv_req_o; all other grant bits are 0.
//     - Handshake moves the rr pointer to (sel+1) mod NR_MASTERS and pushes sel into the order FIFO.
//   Full: when FIFO count == MAX_OUTSTANDING, slv_req_o=0 and no grant is issued. No same-cycle pop bypass.
//   Response path:
//     - On slv_rvalid_i with FIFO not empty: mst_rvalid_o[head]=1 in the same cycle, then pop.
//     - mst_rdata_o/mst_err_o pass through from the slave, unmasked.
//   Responses return in order; the slave guarantees at least 1 cycle between grant and rvalid.
//   Spurious response: slv_rvalid_i while FIFO empty (this includes a push in the same cycle):
//     - no mst_rvalid_o; spurious_o=1 on the next cycle (registered); FIFO unchanged.
//   Simultaneous push+pop: count unchanged; head and tail both advance and wrap at MAX_OUTSTANDING-1.
//   Reset mid-transaction: in-flight entries are discarded; late rvalids then raise spurious_o.
// CONFIGURATION
//   CACHE_ARB_PERF_EN defined:
//     - perf_gnt_cnt_o port exists; counter i increments on each handshake with sel==i.
//     - Counters saturate at all-ones; reset to 0.
//   CACHE_ARB_PERF_EN undefined: port and counters are absent; all other behaviour is identical.
// TESTING
//   1) Reset, then all 4 masters req with gnt=1 each cycle -> grants go to 0,1,2,3,0 on successive cycles.
//   2) m2 requests, gnt=0 for 3 cycles, m0 raises req in cycle 2 -> sel stays 2 and slv_addr_o stays stable;
//      on gnt m2 is granted, then m0.
//   3) MAX_OUTSTANDING=2: two grants (m1, m3) without rvalid -> slv_req_o=0 and outstanding_o=2;
//      rvalid with rdata=0xCAFE0001 -> mst_rvalid_o[1]=1; next rvalid -> mst_rvalid_o[3]=1.
//   4) Push and pop in the same cycle at count=1 -> outstanding_o stays 1; the response routes to the older index.
//   5) slv_rvalid_i with FIFO empty -> no mst_rvalid_o; spurious_o=1 for exactly one cycle.
//   6) PERF_EN: 5 grants to m0 and 2 to m1, then rst_i -> counters read 5/2 before reset and 0/0 after.

Source files
------------

// File: rtl/cache_port_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_rr_arbiter
//   N-master to 1-slave OBI-style arbiter in front of the data cache core port.
//   Round-robin selection with lock-in while the slave stalls a request, and an
//   order FIFO (MAX_OUTSTANDING deep) that routes each response back to the
//   master that issued the matching request. Responses return in order.
//
// Optional feature macro: CACHE_ARB_PERF_EN
//   When defined, per-master saturating grant counters are added and exported
//   on perf_gnt_cnt_o. When undefined, the port and the counters are absent.
//
// Ports
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   mst_req_i       per-master request            [NR_MASTERS]
//   mst_gnt_o       per-master grant              [NR_MASTERS]
//   mst_we_i        per-master write enable       [NR_MASTERS]
//   mst_be_i        per-master byte enables       [NR_MASTERS*BE_WIDTH]
//   mst_addr_i      per-master address            [NR_MASTERS*ADDR_WIDTH]
//   mst_wdata_i     per-master write data         [NR_MASTERS*DATA_WIDTH]
//   mst_rvalid_o    per-master response valid     [NR_MASTERS]
//   mst_rdata_o     read data, broadcast          [DATA_WIDTH]
//   mst_err_o       response error, broadcast
//   slv_req_o/slv_gnt_i/slv_we_o/slv_be_o/slv_addr_o/slv_wdata_o  cache request
//   slv_rvalid_i/slv_rdata_i/slv_err_i                            cache response
//   outstanding_o   order FIFO fill level
//   spurious_o      1-cycle pulse: response arrived with nothing in flight
//   perf_gnt_cnt_o  per-master grant counters (CACHE_ARB_PERF_EN only)
// -----------------------------------------------------------------------------
module cache_port_rr_arbiter #(
  parameter int unsigned NR_MASTERS      = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_WIDTH       = 32,
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned IDX_W    = $clog2(NR_MASTERS),
  localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int unsigned OCNT_W   = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_MASTERS-1:0]            mst_req_i,
  output logic [NR_MASTERS-1:0]            mst_gnt_o,
  input  logic [NR_MASTERS-1:0]            mst_we_i,
  input  logic [NR_MASTERS*BE_WIDTH-1:0]   mst_be_i,
  input  logic [NR_MASTERS*ADDR_WIDTH-1:0] mst_addr_i,
  input  logic [NR_MASTERS*DATA_WIDTH-1:0] mst_wdata_i,
  output logic [NR_MASTERS-1:0]            mst_rvalid_o,
  output logic [DATA_WIDTH-1:0]            mst_rdata_o,
  output logic                             mst_err_o,
  output logic                             slv_req_o,
  input  logic                             slv_gnt_i,
  output logic                             slv_we_o,
  output logic [BE_WIDTH-1:0]              slv_be_o,
  output logic [ADDR_WIDTH-1:0]            slv_addr_o,
  output logic [DATA_WIDTH-1:0]            slv_wdata_o,
  input  logic                             slv_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            slv_rdata_i,
  input  logic                             slv_err_i,
  output logic [OCNT_W-1:0]                outstanding_o,
  output logic                             spurious_o
`ifdef CACHE_ARB_PERF_EN
  ,
  output logic [NR_MASTERS*CNT_WIDTH-1:0]  perf_gnt_cnt_o
`endif
);

  // Arbitration state
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  // Order FIFO: master index of every in-flight request, oldest at head
  logic [IDX_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [OCNT_W-1:0] count_q, count_d;
  logic              spurious_q, spurious_d;

  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] cand;
  logic             arb_found;
  logic [IDX_W-1:0] sel;
  logic             full, empty, handshake, push, pop;

  // Pointer increment that wraps at MAX_OUTSTANDING-1 (depth need not be 2^n)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin search: first requester at or after rr_q, modulo NR_MASTERS
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it unassigned and no latch is inferred.
    arb_idx   = rr_q;
    arb_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < int'(NR_MASTERS); k++) begin
      cand = IDX_W'((int'(rr_q) + k) % int'(NR_MASTERS));
      if (!arb_found && mst_req_i[cand]) begin
        arb_idx   = cand;
        arb_found = 1'b1;
      end
    end
  end

  // A stalled request keeps its master until the handshake completes
  assign sel       = lock_q ? lock_idx_q : arb_idx;
  assign full      = (count_q == OCNT_W'(MAX_OUTSTANDING));
  assign empty     = (count_q == '0);
  assign slv_req_o = (|mst_req_i) & ~full;
  assign handshake = slv_req_o & slv_gnt_i;
  assign push      = handshake;
  // A response with nothing in flight is never popped, even if a push lands
  // in the same cycle: the slave answers at least one cycle after the grant.
  assign pop       = slv_rvalid_i & ~empty;

  assign slv_we_o    = mst_we_i[sel];
  assign slv_be_o    = mst_be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];
  assign slv_addr_o  = mst_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign slv_wdata_o = mst_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

  assign mst_rdata_o   = slv_rdata_i;
  assign mst_err_o     = slv_err_i;
  assign outstanding_o = count_q;
  assign spurious_o    = spurious_q;

  always_comb begin
    mst_gnt_o                 = '0;
    mst_gnt_o[sel]            = handshake;
    mst_rvalid_o              = '0;
    mst_rvalid_o[fifo_q[head_q]] = pop;
  end

  // Next-state logic
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (handshake) begin
      rr_d   = (sel == IDX_W'(NR_MASTERS - 1)) ? '0 : sel + IDX_W'(1);
      lock_d = 1'b0;
    end else if (slv_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end

    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + OCNT_W'(1);
      2'b01:   count_d = count_q - OCNT_W'(1);
      default: count_d = count_q;
    endcase

    spurious_d = slv_rvalid_i & empty;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples the values from before this edge.
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      spurious_q <= spurious_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count_q qualifies every
  // entry, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[tail_q] <= sel;
    end
  end

`ifdef CACHE_ARB_PERF_EN
  logic [CNT_WIDTH-1:0] perf_q [NR_MASTERS];
  logic [CNT_WIDTH-1:0] perf_d [NR_MASTERS];

  // Counters saturate at all-ones instead of wrapping
  always_comb begin
    for (int i = 0; i < int'(NR_MASTERS); i++) begin
      perf_d[i] = perf_q[i];
      if (handshake && (sel == IDX_W'(i)) && (perf_q[i] != '1)) begin
        perf_d[i] = perf_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NR_MASTERS); i++) begin
      if (rst_i) perf_q[i] <= '0;
      else       perf_q[i] <= perf_d[i];
    end
  end

  for (genvar g = 0; g < NR_MASTERS; g++) begin : g_perf_out
    assign perf_gnt_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = perf_q[g];
  end
`endif

endmodule
